// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port block RAM.
// Ownership is granted per burst; read returns are tagged with the issuing requester.
module bram_port_arbiter #(
    parameter int AW        = 7,
    parameter int DW        = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          last0,
    input  logic          last1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t             state_reg, state_next;
    logic               rr_ptr_reg, rr_ptr_next;
    logic [7:0]         beat_cnt_reg, beat_cnt_next;
    logic [RD_LAT-1:0]  tag_valid_reg, tag_valid_next;
    logic [RD_LAT-1:0]  tag_id_reg, tag_id_next;

    logic owner_is1;
    logic accept;
    logic cur_we;
    logic cur_last;
    logic other_req;
    logic release_beat;

    assign gnt0      = (state_reg == OWN0);
    assign gnt1      = (state_reg == OWN1);
    assign owner_is1 = (state_reg == OWN1);

    assign accept    = (gnt0 && req0) || (gnt1 && req1);
    assign cur_we    = owner_is1 ? we1   : we0;
    assign cur_last  = owner_is1 ? last1 : last0;
    assign other_req = owner_is1 ? req0  : req1;

    // Forced release on the MAX_BURST-th beat keeps a stuck requester from starving the other.
    assign release_beat = accept && (cur_last || (beat_cnt_reg == LAST_BEAT));

    assign ram_en   = accept;
    assign ram_we   = accept && cur_we;
    assign ram_addr = owner_is1 ? addr1  : addr0;
    assign ram_din  = owner_is1 ? wdata1 : wdata0;

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req0 && req1)
                    state_next = rr_ptr_reg ? OWN1 : OWN0;
                else if (req0)
                    state_next = OWN0;
                else if (req1)
                    state_next = OWN1;
            end
            OWN0, OWN1: begin
                if (release_beat) begin
                    rr_ptr_next   = ~owner_is1;
                    beat_cnt_next = 8'd0;
                    if (other_req)
                        state_next = owner_is1 ? OWN0 : OWN1;
                    else
                        state_next = IDLE;
                end else if (accept) begin
                    beat_cnt_next = beat_cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read tag pipeline: stage 0 captures the accepted beat, the last stage lines up with ram_dout.
    assign tag_valid_next[0] = accept && !cur_we;
    assign tag_id_next[0]    = owner_is1;

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tag_shift
            assign tag_valid_next[gi] = tag_valid_reg[gi-1];
            assign tag_id_next[gi]    = tag_id_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 1'b0;
            beat_cnt_reg  <= 8'd0;
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            beat_cnt_reg  <= beat_cnt_next;
            tag_valid_reg <= tag_valid_next;
            tag_id_reg    <= tag_id_next;
        end
    end

    assign rvalid0 = tag_valid_reg[RD_LAT-1] && !tag_id_reg[RD_LAT-1];
    assign rvalid1 = tag_valid_reg[RD_LAT-1] &&  tag_id_reg[RD_LAT-1];
    assign rdata   = ram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: arbitration, burst release, locking and tagged read return for two latencies.
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, last0 = 0, last1 = 0;
    logic [6:0]  addr0 = 0, addr1 = 0;
    logic [15:0] wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we;
    logic [15:0] rdata, ram_din;
    logic [6:0]  ram_addr;
    logic [15:0] ram_dout;

    logic        b_req0 = 0, b_req1 = 0, b_last0 = 0, b_last1 = 0;
    logic [6:0]  b_addr0 = 0, b_addr1 = 0;
    logic [15:0] b_wdata = 16'h0;
    logic [15:0] b_ram_dout = 16'h0;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_ram_en, b_ram_we;
    logic [15:0] b_rdata, b_ram_din;
    logic [6:0]  b_ram_addr;

    logic [15:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.AW(7), .DW(16), .RD_LAT(1), .MAX_BURST(100)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .last0(last0), .last1(last1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    bram_port_arbiter #(.AW(7), .DW(16), .RD_LAT(2), .MAX_BURST(100)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .req1(b_req1), .we0(1'b0), .we1(1'b0),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata), .wdata1(b_wdata),
        .last0(b_last0), .last1(b_last1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1), .rdata(b_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
        .ram_dout(b_ram_dout)
    );

    // Single-port RAM, read latency 1, read-before-write
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic w, input int a, input int d, input logic l);
        req0 = r; we0 = w; addr0 = 7'(a); wdata0 = 16'(d); last0 = l;
    endtask

    task automatic drive1(input logic r, input logic w, input int a, input int d, input logic l);
        req1 = r; we1 = w; addr1 = 7'(a); wdata1 = 16'(d); last1 = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic seen1;

        // reset state
        #2;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_ram_en", ram_en, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // 1: write burst addr 0..3 data 1..4
        drive0(1, 1, 0, 1, 0);
        @(negedge clk);
        check("t1_gnt_latency", gnt0, 0);
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            drive0(1, 1, b, b + 1, b == 3);
            @(negedge clk);
            check("t1_gnt0", gnt0, 1);
            check("t1_ram_we", {ram_en, ram_we}, 2'b11);
            check("t1_ram_addr", ram_addr, b);
            check("t1_ram_din", ram_din, b + 1);
            next_cycle();
        end
        drive0(0, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_idle_gnt0", gnt0, 0);
        next_cycle();

        // 2: read burst addr 0..3, data returns one cycle later
        drive0(1, 0, 0, 0, 0);
        @(negedge clk);
        check("t2_gnt_latency", gnt0, 0);
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            drive0(1, 0, b, 0, b == 3);
            @(negedge clk);
            check("t2_ram_rd", {ram_en, ram_we}, 2'b10);
            check("t2_rvalid0", rvalid0, b > 0);
            check("t2_rvalid1", rvalid1, 0);
            if (b > 0) check("t2_rdata", rdata, b);
            next_cycle();
        end
        drive0(0, 0, 0, 0, 0);
        @(negedge clk);
        check("t2_rvalid0_last", rvalid0, 1);
        check("t2_rdata_last", rdata, 4);
        check("t2_rvalid1_last", rvalid1, 0);
        next_cycle();
        @(negedge clk);
        check("t2_rvalid0_done", rvalid0, 0);
        next_cycle();

        // 3: tie from reset, direct handoff, next tie back to 0
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        drive0(1, 1, 20, 7, 0);
        drive1(1, 1, 30, 9, 0);
        @(negedge clk);
        check("t3_idle_gnt", {gnt0, gnt1}, 2'b00);
        next_cycle();
        @(negedge clk);
        check("t3_own0_first", {gnt0, gnt1}, 2'b10);
        next_cycle();
        drive0(1, 1, 21, 8, 1);
        @(negedge clk);
        check("t3_own0_last", {gnt0, gnt1}, 2'b10);
        next_cycle();
        drive0(0, 0, 0, 0, 0);
        drive1(1, 1, 30, 9, 1);
        @(negedge clk);
        check("t3_handoff", {gnt0, gnt1}, 2'b01);
        check("t3_ram_addr1", ram_addr, 30);
        next_cycle();
        drive0(1, 1, 22, 5, 1);
        drive1(1, 1, 31, 6, 1);
        @(negedge clk);
        check("t3_idle_again", {gnt0, gnt1}, 2'b00);
        next_cycle();
        @(negedge clk);
        check("t3_tie_to_0", {gnt0, gnt1}, 2'b10);
        next_cycle();
        drive0(0, 0, 0, 0, 0);
        @(negedge clk);
        check("t3_then_1", {gnt0, gnt1}, 2'b01);
        next_cycle();
        drive1(0, 0, 0, 0, 0);
        @(negedge clk);
        check("t3_end_idle", {gnt0, gnt1}, 2'b00);
        next_cycle();

        // 4: forced release after MAX_BURST beats
        drive0(1, 1, 100, 16'h55, 0);
        drive1(1, 1, 101, 16'h66, 0);
        n0 = 0;
        seen1 = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (gnt1) begin
                seen1 = 1;
                break;
            end
            if (ram_en && gnt0) n0++;
            next_cycle();
        end
        check("t4_beats", n0, 100);
        check("t4_req1_served", seen1, 1);
        check("t4_gnt0_dropped", gnt0, 0);
        next_cycle();
        drive0(0, 0, 0, 0, 0);
        drive1(1, 1, 101, 16'h66, 1);
        @(negedge clk);
        check("t4_own1", gnt1, 1);
        next_cycle();
        drive1(0, 0, 0, 0, 0);
        @(negedge clk);
        check("t4_idle", {gnt0, gnt1}, 2'b00);
        next_cycle();

        // 5: owner drops req mid-burst, ownership is locked
        drive0(1, 0, 0, 0, 0);
        next_cycle();
        @(negedge clk);
        check("t5_first_beat", {gnt0, ram_en}, 2'b11);
        next_cycle();
        drive0(0, 0, 0, 0, 0);
        drive1(1, 0, 2, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_locked", {gnt0, gnt1, ram_en}, 3'b100);
            next_cycle();
        end
        drive0(1, 0, 1, 0, 1);
        @(negedge clk);
        check("t5_resume", {gnt0, ram_en}, 2'b11);
        next_cycle();
        drive0(0, 0, 0, 0, 0);
        drive1(1, 0, 2, 0, 1);
        @(negedge clk);
        check("t5_handoff", {gnt0, gnt1}, 2'b01);
        next_cycle();
        drive1(0, 0, 0, 0, 0);
        next_cycle();

        // 6: RD_LAT=2 instance, read handoff then reset mid-burst
        b_req0 = 1; b_addr0 = 7'd0; b_last0 = 1;
        b_req1 = 1; b_addr1 = 7'd1; b_last1 = 0;
        @(negedge clk);
        check("t6_idle", {b_gnt0, b_gnt1}, 2'b00);
        next_cycle();
        @(negedge clk);
        check("t6_own0", {b_gnt0, b_gnt1}, 2'b10);
        check("t6_rv_none0", {b_rvalid0, b_rvalid1}, 2'b00);
        next_cycle();
        b_req0 = 0; b_last0 = 0;
        @(negedge clk);
        check("t6_own1", {b_gnt0, b_gnt1}, 2'b01);
        check("t6_rv_none1", {b_rvalid0, b_rvalid1}, 2'b00);
        next_cycle();
        @(negedge clk);
        check("t6_rvalid0", {b_rvalid0, b_rvalid1}, 2'b10);
        next_cycle();
        @(negedge clk);
        check("t6_rvalid1", {b_rvalid0, b_rvalid1}, 2'b01);
        check("t6_still_own1", b_gnt1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", {b_gnt0, b_gnt1}, 2'b00);
        check("t6_rst_rvalid", {b_rvalid0, b_rvalid1}, 2'b00);
        #1;
        rst_n = 1'b1;
        b_req1 = 0;
        next_cycle();
        @(negedge clk);
        check("t6_post_rst", {b_gnt0, b_gnt1, b_rvalid0, b_rvalid1}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
